// File: rtl/afe_l2_addrgen_mc.sv
// Multi-channel AFE L2 address generator.
// Holds NCH ring-buffer descriptors and arbitrates per-channel beat requests
// round-robin. It emits one registered L2 byte address per granted beat over a
// valid/ready handshake. Each channel raises a one-cycle event on a watermark
// crossing or at buffer end.
module afe_l2_addrgen_mc #(
  parameter int NCH        = 4,
  parameter int AWIDTH     = 18,
  parameter int TRANS_SIZE = 16,
  localparam int CHW       = $clog2(NCH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NCH*AWIDTH-1:0]      cfg_startaddr_i,
  input  logic [NCH*TRANS_SIZE-1:0]  cfg_size_i,
  input  logic [NCH*2-1:0]           cfg_datasize_i,
  input  logic [NCH*TRANS_SIZE-1:0]  cfg_thresh_i,
  input  logic [NCH-1:0]             cfg_continuous_i,
  input  logic [NCH-1:0]             cfg_en_i,
  input  logic [NCH-1:0]             cfg_clr_i,
  output logic [NCH-1:0]             cfg_en_o,
  output logic [NCH*AWIDTH-1:0]      cfg_curr_addr_o,
  output logic [NCH*TRANS_SIZE-1:0]  cfg_bytes_left_o,
  output logic [NCH*TRANS_SIZE-1:0]  cfg_wr_ptr_o,
  input  logic [NCH-1:0]             req_i,
  output logic [NCH-1:0]             gnt_o,
  output logic [AWIDTH-1:0]          addr_o,
  output logic [CHW-1:0]             ch_o,
  output logic [1:0]                 size_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [NCH-1:0]             event_o,
  output logic [NCH-1:0]             err_o
);

  // Width wide enough to form curr_addr - startaddr without losing modulo bits.
  localparam int DW = (AWIDTH > TRANS_SIZE) ? AWIDTH : TRANS_SIZE;

  // Per-channel descriptor state.
  logic [TRANS_SIZE-1:0] cnt_q   [NCH];
  logic [TRANS_SIZE-1:0] cnt_d   [NCH];
  logic [AWIDTH-1:0]     caddr_q [NCH];
  logic [AWIDTH-1:0]     caddr_d [NCH];
  logic [NCH-1:0]        en_q, en_d;
  logic [NCH-1:0]        err_q, err_d;
  logic [CHW-1:0]        ptr_q, ptr_d;

  // Output stage.
  logic                  valid_q, valid_d;
  logic [AWIDTH-1:0]     beat_addr_q, beat_addr_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [1:0]            size_q, size_d;
  logic [NCH-1:0]        event_q, event_d;

  // Arbitration results and winner attributes.
  logic [NCH-1:0]        load, masked, elig, gnt;
  logic                  free, found;
  logic [CHW-1:0]        win;
  int                    idx;
  logic [1:0]            ds_w;
  logic [2:0]            incr_w;
  logic [TRANS_SIZE-1:0] cnt_w, thr_w, cnt_after_w;
  logic                  last_w, evt_w;

  // Round-robin arbiter: first eligible channel at or after the pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    gnt    = '0;
    win    = '0;
    found  = 1'b0;
    idx    = 0;
    load   = cfg_en_i & ~en_q;
    masked = load | cfg_clr_i;
    elig   = req_i & en_q & ~masked;
    free   = ~valid_q | ready_i;
    if (free) begin
      for (int i = 0; i < NCH; i++) begin
        idx = (int'(ptr_q) + i) % NCH;
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = CHW'(idx);
        end
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  // Beat size, last-beat and event decode for the winning channel.
  always_comb begin
    ds_w = cfg_datasize_i[win*2 +: 2];
    case (ds_w)
      2'b00:   incr_w = 3'd1;
      2'b01:   incr_w = 3'd2;
      default: incr_w = 3'd4;
    endcase
    cnt_w       = cnt_q[win];
    thr_w       = cfg_thresh_i[win*TRANS_SIZE +: TRANS_SIZE];
    cnt_after_w = cnt_w - TRANS_SIZE'(incr_w);
    last_w      = (cnt_w <= TRANS_SIZE'(incr_w));
    evt_w       = last_w ||
                  ((thr_w != '0) && (cnt_w > thr_w) && (thr_w >= cnt_after_w));
  end

  // Per-channel descriptor update: load, then clear, then grant.
  always_comb begin
    en_d  = en_q;
    err_d = err_q;
    ptr_d = ptr_q;
    if (found) ptr_d = (int'(win) == NCH - 1) ? '0 : win + 1'b1;
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c]   = cnt_q[c];
      caddr_d[c] = caddr_q[c];
      if (load[c]) begin
        cnt_d[c]   = cfg_size_i[c*TRANS_SIZE +: TRANS_SIZE];
        caddr_d[c] = cfg_startaddr_i[c*AWIDTH +: AWIDTH];
        en_d[c]    = 1'b1;
      end else if (cfg_clr_i[c]) begin
        cnt_d[c]   = '0;
        caddr_d[c] = '0;
        en_d[c]    = 1'b0;
      end else if (gnt[c]) begin
        if (!last_w) begin
          cnt_d[c]   = cnt_after_w;
          caddr_d[c] = caddr_q[c] + AWIDTH'(incr_w);
        end else if (cfg_continuous_i[c] || cfg_en_i[c]) begin
          cnt_d[c]   = cfg_size_i[c*TRANS_SIZE +: TRANS_SIZE];
          caddr_d[c] = cfg_startaddr_i[c*AWIDTH +: AWIDTH];
        end else begin
          cnt_d[c]   = '0;
          caddr_d[c] = '0;
          en_d[c]    = 1'b0;
        end
      end
      if (cfg_clr_i[c] && !load[c]) err_d[c] = 1'b0;
      else if (req_i[c] && !en_q[c] && !cfg_en_i[c]) err_d[c] = 1'b1;
    end
  end

  // Output stage: load on grant, hold under backpressure, drop on acceptance.
  always_comb begin
    valid_d     = valid_q;
    beat_addr_d = beat_addr_q;
    ch_d        = ch_q;
    size_d      = size_q;
    event_d     = '0;
    if (found) begin
      valid_d     = 1'b1;
      beat_addr_d = caddr_q[win];
      ch_d        = win;
      size_d      = ds_w;
      if (evt_w) event_d = gnt;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]   <= '0;
        caddr_q[c] <= '0;
      end
      en_q        <= '0;
      err_q       <= '0;
      ptr_q       <= '0;
      valid_q     <= 1'b0;
      beat_addr_q <= '0;
      ch_q        <= '0;
      size_q      <= '0;
      event_q     <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]   <= cnt_d[c];
        caddr_q[c] <= caddr_d[c];
      end
      en_q        <= en_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      beat_addr_q <= beat_addr_d;
      ch_q        <= ch_d;
      size_q      <= size_d;
      event_q     <= event_d;
    end
  end

  // Flatten per-channel status; write pointer is taken modulo 2^TRANS_SIZE.
  always_comb begin
    logic [DW-1:0] diff;
    diff = '0;
    for (int c = 0; c < NCH; c++) begin
      diff = DW'(caddr_q[c]) - DW'(cfg_startaddr_i[c*AWIDTH +: AWIDTH]);
      cfg_curr_addr_o[c*AWIDTH +: AWIDTH]          = caddr_q[c];
      cfg_bytes_left_o[c*TRANS_SIZE +: TRANS_SIZE] = cnt_q[c];
      cfg_wr_ptr_o[c*TRANS_SIZE +: TRANS_SIZE]     = diff[TRANS_SIZE-1:0];
    end
  end

  assign cfg_en_o = en_q;
  assign err_o    = err_q;
  assign gnt_o    = gnt;
  assign valid_o  = valid_q;
  assign addr_o   = beat_addr_q;
  assign ch_o     = ch_q;
  assign size_o   = size_q;
  assign event_o  = event_q;

endmodule

// File: tb/tb_afe_l2_addrgen_mc.sv
// Self-checking bench for afe_l2_addrgen_mc: a vector table for the
// single-channel stream plus directed sequences for the multi-cycle cases.
module tb_afe_l2_addrgen_mc;

  localparam int NCH = 4;
  localparam int AW  = 18;
  localparam int TS  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NCH*AW-1:0] cfg_startaddr_i;
  logic [NCH*TS-1:0] cfg_size_i;
  logic [NCH*2-1:0]  cfg_datasize_i;
  logic [NCH*TS-1:0] cfg_thresh_i;
  logic [NCH-1:0]    cfg_continuous_i, cfg_en_i, cfg_clr_i;
  logic [NCH-1:0]    cfg_en_o;
  logic [NCH*AW-1:0] cfg_curr_addr_o;
  logic [NCH*TS-1:0] cfg_bytes_left_o, cfg_wr_ptr_o;
  logic [NCH-1:0]    req_i, gnt_o, event_o, err_o;
  logic [AW-1:0]     addr_o;
  logic [1:0]        ch_o, size_o;
  logic              valid_o, ready_i;

  int n_pass  = 0;
  int n_total = 0;

  afe_l2_addrgen_mc #(.NCH(NCH), .AWIDTH(AW), .TRANS_SIZE(TS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_startaddr_i(cfg_startaddr_i), .cfg_size_i(cfg_size_i),
    .cfg_datasize_i(cfg_datasize_i), .cfg_thresh_i(cfg_thresh_i),
    .cfg_continuous_i(cfg_continuous_i), .cfg_en_i(cfg_en_i),
    .cfg_clr_i(cfg_clr_i), .cfg_en_o(cfg_en_o),
    .cfg_curr_addr_o(cfg_curr_addr_o), .cfg_bytes_left_o(cfg_bytes_left_o),
    .cfg_wr_ptr_o(cfg_wr_ptr_o), .req_i(req_i), .gnt_o(gnt_o),
    .addr_o(addr_o), .ch_o(ch_o), .size_o(size_o), .valid_o(valid_o),
    .ready_i(ready_i), .event_o(event_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  req;
    logic        ready;
    logic [3:0]  gnt;
    logic        valid;
    logic [17:0] addr;
    logic [3:0]  evt;
    logic [3:0]  en;
    logic [15:0] left;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] left_of(input int c);
    return cfg_bytes_left_o[c*TS +: TS];
  endfunction

  task automatic set_ch(input int c, input logic [17:0] start, input logic [15:0] size,
                        input logic [1:0] ds, input logic [15:0] thr, input logic cont);
    cfg_startaddr_i[c*AW +: AW] = start;
    cfg_size_i[c*TS +: TS]      = size;
    cfg_datasize_i[c*2 +: 2]    = ds;
    cfg_thresh_i[c*TS +: TS]    = thr;
    cfg_continuous_i[c]         = cont;
  endtask

  // Drive request/ready at the falling edge; combinational grant is stable #1 later.
  task automatic cyc_in(input logic [3:0] req, input logic rdy);
    @(negedge clk_i);
    req_i   = req;
    ready_i = rdy;
    #1;
  endtask

  // Registered outputs are sampled #1 after the rising edge.
  task automatic post();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_en(input logic [3:0] m);
    @(negedge clk_i);
    req_i     = '0;
    cfg_en_i  = m;
    post();
    cfg_en_i  = '0;
  endtask

  task automatic pulse_clr(input logic [3:0] m);
    @(negedge clk_i);
    req_i     = '0;
    cfg_clr_i = m;
    post();
    cfg_clr_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Round-robin / backpressure expectations: grant one-hot and beat address.
  logic [3:0]  rr_req [12];
  logic [3:0]  rr_gnt [12];
  logic [17:0] rr_adr [12];

  initial begin
    rst_i = 1'b1;
    cfg_startaddr_i = '0; cfg_size_i = '0; cfg_datasize_i = '0;
    cfg_thresh_i = '0; cfg_continuous_i = '0; cfg_en_i = '0; cfg_clr_i = '0;
    req_i = 4'hF; ready_i = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk_i);
    #1;
    check("reset valid", valid_o, 0);
    check("reset en", cfg_en_o, 0);
    check("reset err", err_o, 0);
    check("reset gnt", gnt_o, 0);
    check("reset event", event_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    req_i = '0;

    // ---------------- single channel, table driven ----------------
    tbl[0] = '{req:4'h1, ready:1'b1, gnt:4'h1, valid:1'b1, addr:18'h100, evt:4'h0, en:4'h1, left:16'd12};
    tbl[1] = '{req:4'h1, ready:1'b1, gnt:4'h1, valid:1'b1, addr:18'h104, evt:4'h1, en:4'h1, left:16'd8};
    tbl[2] = '{req:4'h1, ready:1'b1, gnt:4'h1, valid:1'b1, addr:18'h108, evt:4'h0, en:4'h1, left:16'd4};
    tbl[3] = '{req:4'h1, ready:1'b1, gnt:4'h1, valid:1'b1, addr:18'h10C, evt:4'h1, en:4'h0, left:16'd0};
    tbl[4] = '{req:4'h0, ready:1'b1, gnt:4'h0, valid:1'b0, addr:18'h0,   evt:4'h0, en:4'h0, left:16'd0};

    set_ch(0, 18'h100, 16'd16, 2'b10, 16'd8, 1'b0);
    pulse_en(4'h1);
    for (int i = 0; i < 5; i++) begin
      cyc_in(tbl[i].req, tbl[i].ready);
      check($sformatf("single v%0d gnt", i), gnt_o, tbl[i].gnt);
      post();
      check($sformatf("single v%0d valid", i), valid_o, tbl[i].valid);
      if (tbl[i].valid) begin
        check($sformatf("single v%0d addr", i), addr_o, tbl[i].addr);
        check($sformatf("single v%0d size", i), size_o, 2'b10);
      end
      check($sformatf("single v%0d event", i), event_o, tbl[i].evt);
      check($sformatf("single v%0d en", i), cfg_en_o, tbl[i].en);
      check($sformatf("single v%0d left", i), left_of(0), tbl[i].left);
    end
    // Stopped channel: addr 0 - start 0x100, modulo 2^16.
    check("single wr_ptr wrap", cfg_wr_ptr_o[15:0], 16'hFF00);

    // ---------------- continuous wrap ----------------
    set_ch(0, 18'h100, 16'd16, 2'b10, 16'd8, 1'b1);
    pulse_en(4'h1);
    for (int i = 0; i < 5; i++) begin
      cyc_in(4'h1, 1'b1);
      post();
      check($sformatf("cont beat%0d addr", i), addr_o, (i == 4) ? 18'h100 : 18'h100 + 18'(4 * i));
      if (i == 3) begin
        check("cont reload left", left_of(0), 16'd16);
        check("cont end event", event_o, 4'h1);
        check("cont en held", cfg_en_o, 4'h1);
      end
    end
    check("cont left after wrap", left_of(0), 16'd12);
    check("cont wr_ptr", cfg_wr_ptr_o[15:0], 16'd4);
    pulse_clr(4'h1);
    check("cont clr en", cfg_en_o, 4'h0);

    // ---------------- round robin + backpressure ----------------
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 18'(18'h400 + 18'h1000 * c), 16'd256, 2'b00, 16'd0, 1'b0);
    pulse_en(4'hF);
    rr_req = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
    rr_gnt = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4, 4'h8, 4'h1, 4'h4};
    rr_adr = '{18'h400, 18'h1400, 18'h2400, 18'h3400, 18'h401, 18'h2401, 18'h3401,
               18'h402, 18'h2402, 18'h3402, 18'h403, 18'h2403};
    for (int i = 0; i < 12; i++) begin
      if (i == 9) begin
        // Hold the 0x2402 beat for three cycles.
        for (int k = 0; k < 3; k++) begin
          cyc_in(4'hD, 1'b0);
          check($sformatf("bp%0d gnt", k), gnt_o, 4'h0);
          post();
          check($sformatf("bp%0d valid", k), valid_o, 1'b1);
          check($sformatf("bp%0d addr", k), addr_o, 18'h2402);
          check($sformatf("bp%0d ch", k), ch_o, 2'd2);
          check($sformatf("bp%0d left ch2", k), left_of(2), 16'd253);
          check($sformatf("bp%0d left ch3", k), left_of(3), 16'd254);
        end
      end
      cyc_in(rr_req[i], 1'b1);
      check($sformatf("rr%0d gnt", i), gnt_o, rr_gnt[i]);
      post();
      check($sformatf("rr%0d addr", i), addr_o, rr_adr[i]);
    end

    // ---------------- simultaneous clear and request ----------------
    @(negedge clk_i);
    req_i = 4'h4; cfg_clr_i = 4'h4; ready_i = 1'b1;
    #1;
    check("sim clr gnt", gnt_o, 4'h0);
    post();
    cfg_clr_i = '0;
    check("sim clr en", cfg_en_o, 4'hB);
    check("sim clr err", err_o, 4'h0);
    cyc_in(4'h4, 1'b1);
    check("inactive req gnt", gnt_o, 4'h0);
    post();
    check("err set", err_o, 4'h4);
    cyc_in(4'h0, 1'b1);
    post();
    check("err sticky", err_o, 4'h4);
    pulse_clr(4'h4);
    check("err cleared", err_o, 4'h0);
    cyc_in(4'h4, 1'b1);
    post();
    check("err set again", err_o, 4'h4);

    // ---------------- asynchronous reset mid-stream ----------------
    cyc_in(4'h1, 1'b1);
    check("pre-rst gnt0", gnt_o, 4'h1);
    post();
    cyc_in(4'h1, 1'b1);
    post();
    check("pre-rst valid", valid_o, 1'b1);
    #2;
    rst_i = 1'b1;
    req_i = '0;
    #1;
    check("async rst valid", valid_o, 1'b0);
    check("async rst event", event_o, 4'h0);
    check("async rst en", cfg_en_o, 4'h0);
    check("async rst err", err_o, 4'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    pulse_en(4'hF);
    cyc_in(4'hF, 1'b1);
    check("post-rst first gnt", gnt_o, 4'h1);
    post();
    check("post-rst ch", ch_o, 2'd0);
    check("post-rst addr", addr_o, 18'h400);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
